// File: rtl/hdc_stream_classifier.sv
// Streaming hyperdimensional text classifier: bundles item hypervectors of an
// incoming character stream, thresholds to a binary query and Hamming-searches class vectors.
module hdc_stream_classifier #(
  parameter int DIM       = 1024,
  parameter int W         = 64,
  parameter int NUM_SYM   = 37,
  parameter int NUM_CLASS = 2,
  parameter int MAX_LEN   = 160,
  localparam int WORDS    = DIM / W,
  localparam int WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int ROW_W    = $clog2((NUM_SYM > NUM_CLASS) ? NUM_SYM : NUM_CLASS),
  localparam int CLS_W    = $clog2(NUM_CLASS),
  localparam int DIST_W   = $clog2(DIM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  input  logic              cfg_we,
  input  logic              cfg_tgt,
  input  logic [ROW_W-1:0]  cfg_row,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic [W-1:0]      cfg_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic [DIST_W-1:0] out_dist,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int SYM_W = $clog2(NUM_SYM);

  typedef enum logic [2:0] {IDLE, ACCUM, THRESH, SEARCH, DONE} state_t;

  state_t state_reg, state_next;

  logic [DIM-1:0]    item_mem  [NUM_SYM];
  logic [DIM-1:0]    class_mem [NUM_CLASS];
  logic [CNT_W-1:0]  cnt_reg   [DIM];
  logic [CNT_W-1:0]  cnt_next  [DIM];
  logic [DIM-1:0]    q_reg, q_next;
  logic [CNT_W-1:0]  len_reg;
  logic              ovf_reg;
  logic              ready_reg;

  logic [WORD_W-1:0] word_reg;
  logic [CLS_W-1:0]  cls_reg, best_cls_reg;
  logic [DIST_W-1:0] acc_reg, best_reg;

  logic              out_valid_reg, out_ovf_reg;
  logic [CLS_W-1:0]  out_class_reg;
  logic [DIST_W-1:0] out_dist_reg;

  function automatic logic [SYM_W-1:0] fold_char(input logic [7:0] ch);
    logic [7:0] s;
    s = 8'd0;
    if (ch >= 8'h41 && ch <= 8'h5A)      s = ch - 8'd54;  // 'A' -> 11
    else if (ch >= 8'h61 && ch <= 8'h7A) s = ch - 8'd86;  // 'a' -> 11
    else if (ch >= 8'h30 && ch <= 8'h39) s = ch - 8'd47;  // '0' -> 1
    return s[SYM_W-1:0];
  endfunction

  function automatic logic [DIST_W-1:0] popcount(input logic [W-1:0] v);
    logic [DIST_W-1:0] n;
    n = '0;
    for (int k = 0; k < W; k++) n = n + DIST_W'(v[k]);
    return n;
  endfunction

  logic             accept, len_full;
  logic             cfg_ok, item_wr, class_wr;
  logic [SYM_W-1:0] sym;
  logic [DIM-1:0]   item_eff;

  assign accept   = in_valid && ready_reg;
  assign len_full = (len_reg == CNT_W'(MAX_LEN));
  assign cfg_ok   = cfg_we && (state_reg == IDLE);
  assign item_wr  = cfg_ok && !cfg_tgt && (int'(cfg_row) < NUM_SYM);
  assign class_wr = cfg_ok && cfg_tgt && (int'(cfg_row) < NUM_CLASS);
  assign sym      = fold_char(in_char);

  // A config write landing in the same cycle as a character is forwarded so
  // the character sees the freshly written word.
  always_comb begin
    item_eff = item_mem[sym];
    if (item_wr && (cfg_row == ROW_W'(sym)))
      item_eff[cfg_word*W +: W] = cfg_wdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_dim
      assign cnt_next[gi] = !accept              ? cnt_reg[gi] :
                            (state_reg == IDLE)  ? CNT_W'(item_eff[gi]) :
                            len_full             ? cnt_reg[gi] :
                                                   cnt_reg[gi] + CNT_W'(item_eff[gi]);
      assign q_next[gi]   = (state_reg == THRESH) ? ({cnt_reg[gi], 1'b0} > {1'b0, len_reg})
                                                  : q_reg[gi];
    end
  endgenerate

  logic [W-1:0]      q_word, cls_word;
  logic [DIST_W-1:0] acc_sum;
  logic              last_word, last_cls, better;

  assign q_word    = q_reg[word_reg*W +: W];
  assign cls_word  = class_mem[cls_reg][word_reg*W +: W];
  assign acc_sum   = acc_reg + popcount(q_word ^ cls_word);
  assign last_word = (word_reg == WORD_W'(WORDS - 1));
  assign last_cls  = (cls_reg == CLS_W'(NUM_CLASS - 1));
  assign better    = (cls_reg == '0) || (acc_sum < best_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ACCUM: if (accept) state_next = in_last ? THRESH : ACCUM;
      THRESH:      state_next = SEARCH;
      SEARCH:      if (last_word && last_cls) state_next = DONE;
      DONE:        if (out_ready) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SYM; i++)   item_mem[i]  <= '0;
      for (int i = 0; i < NUM_CLASS; i++) class_mem[i] <= '0;
    end else begin
      if (item_wr)  item_mem[cfg_row][cfg_word*W +: W] <= cfg_wdata;
      if (class_wr) class_mem[cfg_row[CLS_W-1:0]][cfg_word*W +: W] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      for (int i = 0; i < DIM; i++) cnt_reg[i] <= '0;
      q_reg         <= '0;
      len_reg       <= '0;
      ovf_reg       <= 1'b0;
      word_reg      <= '0;
      cls_reg       <= '0;
      acc_reg       <= '0;
      best_reg      <= '0;
      best_cls_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_class_reg <= '0;
      out_dist_reg  <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == IDLE) || (state_next == ACCUM);
      for (int i = 0; i < DIM; i++) cnt_reg[i] <= cnt_next[i];
      q_reg <= q_next;

      if (accept) begin
        if (state_reg == IDLE) begin
          len_reg <= CNT_W'(1);
          ovf_reg <= 1'b0;
        end else if (len_full) begin
          ovf_reg <= 1'b1;
        end else begin
          len_reg <= len_reg + 1'b1;
        end
      end

      if (state_reg == THRESH) begin
        word_reg <= '0;
        cls_reg  <= '0;
        acc_reg  <= '0;
      end

      if (state_reg == SEARCH) begin
        if (last_word) begin
          acc_reg  <= '0;
          word_reg <= '0;
          cls_reg  <= cls_reg + 1'b1;
          if (better) begin
            best_reg     <= acc_sum;
            best_cls_reg <= cls_reg;
          end
          // Final class: fold its own comparison straight into the result.
          if (last_cls) begin
            out_valid_reg <= 1'b1;
            out_class_reg <= better ? cls_reg : best_cls_reg;
            out_dist_reg  <= better ? acc_sum : best_reg;
            out_ovf_reg   <= ovf_reg;
          end
        end else begin
          acc_reg  <= acc_sum;
          word_reg <= word_reg + 1'b1;
        end
      end

      if ((state_reg == DONE) && out_ready) out_valid_reg <= 1'b0;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = out_valid_reg;
  assign out_class = out_class_reg;
  assign out_dist  = out_dist_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_hdc_stream_classifier.sv
// Directed bench for hdc_stream_classifier in the small configuration
// (DIM=64, W=16, NUM_CLASS=2, MAX_LEN=160) with hand-computed expectations.
module tb_hdc_stream_classifier;

  localparam int DIM       = 64;
  localparam int W         = 16;
  localparam int NUM_CLASS = 2;
  localparam int MAX_LEN   = 160;

  localparam logic [63:0] Q_AB = 64'hFFFF_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic        in_last = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_tgt = 1'b0;
  logic [5:0]  cfg_row = '0;
  logic [1:0]  cfg_word = '0;
  logic [15:0] cfg_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:0]  out_class;
  logic [6:0]  out_dist;
  logic        out_ovf;

  always #5 clk = ~clk;

  hdc_stream_classifier #(
    .DIM(DIM), .W(W), .NUM_SYM(37), .NUM_CLASS(NUM_CLASS), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .cfg_we(cfg_we), .cfg_tgt(cfg_tgt), .cfg_row(cfg_row), .cfg_word(cfg_word),
    .cfg_wdata(cfg_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_dist(out_dist), .out_ovf(out_ovf)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;
  byte unsigned msg_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load_row(input bit tgt, input int row, input logic [63:0] val);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_tgt   = tgt;
      cfg_row   = 6'(row);
      cfg_word  = 2'(w);
      cfg_wdata = val[w*16 +: 16];
      @(posedge clk);
    end
    #1 cfg_we = 1'b0;
  endtask

  task automatic send_bytes();
    for (int i = 0; i < msg_q.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    send_bytes();
  endtask

  task automatic expect_result(input string tag, input int exp_cls, input int exp_dist,
                               input bit exp_ovf);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    $display("%s: class=%0d dist=%0d ovf=%0b latency=%0d", tag, out_class, out_dist, out_ovf, n);
    check({tag, "/latency"}, 64'(n), 64'd9);
    check({tag, "/class"}, 64'(out_class), 64'(exp_cls));
    check({tag, "/dist"}, 64'(out_dist), 64'(exp_dist));
    check({tag, "/ovf"}, 64'(out_ovf), 64'(exp_ovf));
    check({tag, "/in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "/ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;

    // Reset held with a pending character.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_char  = 8'h61;
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready_low", 64'(in_ready), 64'd0);
    check("rst/out_valid_low", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst/in_ready_high", 64'(in_ready), 64'd1);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_class", 64'(out_class), 64'd0);
    check("rst/out_dist", 64'(out_dist), 64'd0);
    check("rst/out_ovf", 64'(out_ovf), 64'd0);

    // 'a' with word 0 of item[11] written in the same cycle as the character.
    load_row(1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    load_row(1'b1, 1, 64'h0);
    load_row(1'b0, 11, 64'hFFFF_FFFF_FFFF_0000);
    @(negedge clk);
    cfg_we = 1'b1; cfg_tgt = 1'b0; cfg_row = 6'd11; cfg_word = 2'd0; cfg_wdata = 16'hFFFF;
    in_valid = 1'b1; in_char = 8'h61; in_last = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    expect_result("single_a", 0, 0, 1'b0);
    take_result("single_a");

    // Majority with tie -> 0.
    load_row(1'b0, 11, 64'hFFFF_0000_FFFF_0000);
    load_row(1'b0, 12, 64'hFFFF_FFFF_0000_0000);
    load_row(1'b1, 0, Q_AB);
    load_row(1'b1, 1, ~Q_AB);
    send_str("ab");
    expect_result("ab", 0, 0, 1'b0);
    take_result("ab");

    load_row(1'b1, 0, ~Q_AB);
    load_row(1'b1, 1, Q_AB);
    send_str("ab");
    expect_result("ab_swap", 1, 0, 1'b0);
    take_result("ab_swap");

    // Equal classes: lower index wins.
    load_row(1'b1, 0, 64'h0000_0000_FFFF_FFFF);
    load_row(1'b1, 1, 64'h0000_0000_FFFF_FFFF);
    send_str("ab");
    expect_result("dist_tie", 0, 48, 1'b0);
    take_result("dist_tie");

    // Symbol folding.
    load_row(1'b1, 0, 64'h0000_0000_0000_FFFF);
    load_row(1'b1, 1, 64'hFFFF_0000_0000_0000);
    load_row(1'b0, 10, 64'hFFFF_0000_0000_0000);
    load_row(1'b0, 36, 64'h0000_0000_0000_FFFF);
    send_str("A");
    expect_result("upper_A", 1, 16, 1'b0);
    take_result("upper_A");
    send_str("a");
    expect_result("lower_a", 1, 16, 1'b0);
    take_result("lower_a");
    send_str("?");
    expect_result("other_q", 0, 16, 1'b0);
    take_result("other_q");
    send_str("9");
    expect_result("digit_9", 1, 0, 1'b0);
    take_result("digit_9");
    send_str("z");
    expect_result("lower_z", 0, 0, 1'b0);
    take_result("lower_z");

    // Overflow: 80 '1' + 80 '?' is exactly MAX_LEN (tie -> q=0); ten extra '1's must be ignored.
    load_row(1'b0, 2, 64'h0000_0000_FFFF_FFFF);
    load_row(1'b1, 0, 64'h0);
    load_row(1'b1, 1, 64'h0000_0000_FFFF_FFFF);
    msg_q.delete();
    for (int i = 0; i < 80; i++) msg_q.push_back(8'h31);
    for (int i = 0; i < 80; i++) msg_q.push_back(8'h3F);
    send_bytes();
    expect_result("len160", 0, 0, 1'b0);
    take_result("len160");
    msg_q.delete();
    for (int i = 0; i < 80; i++) msg_q.push_back(8'h31);
    for (int i = 0; i < 80; i++) msg_q.push_back(8'h3F);
    for (int i = 0; i < 10; i++) msg_q.push_back(8'h31);
    send_bytes();
    expect_result("len170", 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold/valid", 64'(out_valid), 64'd1);
      check("hold/class", 64'(out_class), 64'd0);
      check("hold/dist", 64'(out_dist), 64'd0);
      check("hold/ovf", 64'(out_ovf), 64'd1);
      check("hold/in_ready", 64'(in_ready), 64'd0);
    end
    take_result("len170");

    // Config writes outside IDLE are dropped.
    load_row(1'b1, 0, Q_AB);
    load_row(1'b1, 1, ~Q_AB);
    send_str("ab");
    cfg_we = 1'b1; cfg_tgt = 1'b1; cfg_row = 6'd0; cfg_word = 2'd3; cfg_wdata = 16'h0000;
    expect_result("cfg_busy", 0, 0, 1'b0);
    cfg_we = 1'b0;
    take_result("cfg_busy");
    send_str("ab");
    expect_result("cfg_busy_after", 0, 0, 1'b0);
    take_result("cfg_busy_after");

    // Reset in the middle of a search.
    send_str("ab");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst/valid", 64'(out_valid), 64'd0);
    check("midrst/in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("midrst/no_result", 64'(seen), 64'd0);
    check("midrst/in_ready", 64'(in_ready), 64'd1);

    // Item memory was cleared: q=0 is nearest to the all-zero class 1.
    load_row(1'b1, 0, Q_AB);
    load_row(1'b1, 1, 64'h0);
    send_str("ab");
    expect_result("post_rst_cleared", 1, 0, 1'b0);
    take_result("post_rst_cleared");
    load_row(1'b0, 11, 64'hFFFF_0000_FFFF_0000);
    load_row(1'b0, 12, 64'hFFFF_FFFF_0000_0000);
    send_str("ab");
    expect_result("post_rst", 0, 0, 1'b0);
    take_result("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
